// File: rtl/w0rm_mem_arbiter.sv
// rtl/w0rm_mem_arbiter.sv - shares one memory bus between the W0RM fetch port and data port
module w0rm_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int INST_WIDTH      = 16,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                  core_clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic                  inst_req_i,
    output logic [INST_WIDTH-1:0] inst_data_o,
    output logic                  inst_valid_o,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  mem_req_i,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_valid_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_read_o,
    output logic                  bus_write_o,
    output logic                  bus_valid_o,
    input  logic                  bus_ready_i,
    input  logic [DATA_WIDTH-1:0] bus_data_i,
    input  logic                  bus_valid_i,
    output logic [1:0]            grant_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_INST = 2'b01;
    localparam logic [1:0] GRANT_DATA = 2'b10;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    logic [3:0]              streak_q;
    logic [7:0]              tmo_q;
    logic                    inst_busy_q;
    logic [ADDR_WIDTH-1:1]   inst_addr_q;
    logic                    data_busy_q;
    logic [ADDR_WIDTH-1:2]   data_addr_q;
    logic [DATA_WIDTH-1:0]   data_wdata_q;
    logic                    data_wr_q;

    logic                    resp_done;
    logic                    inst_free;
    logic                    data_free;
    logic                    inst_take;
    logic                    inst_drop;
    logic                    data_take;
    logic                    data_drop;
    logic                    pick_data;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic [INST_WIDTH-1:0]   resp_half;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{inst_addr_i[0], mem_addr_i[1:0]};

    assign resp_done = (state_q == S_RESP) && (bus_valid_i || (tmo_q == TMO_LAST));
    assign resp_data = bus_valid_i ? bus_data_i : '0;
    assign resp_half = inst_addr_q[1] ? resp_data[DATA_WIDTH-1:INST_WIDTH]
                                      : resp_data[INST_WIDTH-1:0];

    // A port whose response completes on this edge may already queue its next request.
    assign inst_free = !inst_busy_q || (resp_done && (grant_o == GRANT_INST));
    assign data_free = !data_busy_q || (resp_done && (grant_o == GRANT_DATA));
    assign inst_take = inst_req_i && inst_free;
    assign inst_drop = inst_req_i && !inst_free;
    assign data_take = mem_req_i && (mem_read_i ^ mem_write_i) && data_free;
    assign data_drop = mem_req_i && !data_take;

    assign pick_data = data_busy_q && !(inst_busy_q && (streak_q == STREAK_MAX));

    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            streak_q     <= '0;
            tmo_q        <= '0;
            inst_busy_q  <= 1'b0;
            inst_addr_q  <= '0;
            data_busy_q  <= 1'b0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            data_wr_q    <= 1'b0;
            inst_data_o  <= '0;
            inst_valid_o <= 1'b0;
            mem_data_o   <= '0;
            mem_valid_o  <= 1'b0;
            bus_addr_o   <= '0;
            bus_data_o   <= '0;
            bus_read_o   <= 1'b0;
            bus_write_o  <= 1'b0;
            bus_valid_o  <= 1'b0;
            grant_o      <= GRANT_NONE;
            err_o        <= 1'b0;
        end else begin
            inst_valid_o <= 1'b0;
            mem_valid_o  <= 1'b0;
            if (inst_drop || data_drop) begin
                err_o <= 1'b1;
            end
            if (!inst_busy_q) begin
                streak_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (pick_data) begin
                        grant_o     <= GRANT_DATA;
                        bus_valid_o <= 1'b1;
                        bus_addr_o  <= {data_addr_q, 2'b00};
                        bus_data_o  <= data_wdata_q;
                        bus_read_o  <= !data_wr_q;
                        bus_write_o <= data_wr_q;
                        streak_q    <= inst_busy_q ? streak_q + 4'd1 : 4'd0;
                        state_q     <= S_REQ;
                    end else if (inst_busy_q) begin
                        grant_o     <= GRANT_INST;
                        bus_valid_o <= 1'b1;
                        bus_addr_o  <= {inst_addr_q[ADDR_WIDTH-1:2], 2'b00};
                        bus_data_o  <= '0;
                        bus_read_o  <= 1'b1;
                        bus_write_o <= 1'b0;
                        streak_q    <= '0;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_ready_i) begin
                        bus_valid_o <= 1'b0;
                        bus_read_o  <= 1'b0;
                        bus_write_o <= 1'b0;
                        tmo_q       <= '0;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_done) begin
                        state_q <= S_IDLE;
                        grant_o <= GRANT_NONE;
                        if (!bus_valid_i) begin
                            err_o <= 1'b1;
                        end
                        if (grant_o == GRANT_INST) begin
                            inst_valid_o <= 1'b1;
                            inst_data_o  <= resp_half;
                            inst_busy_q  <= 1'b0;
                        end else begin
                            mem_valid_o <= 1'b1;
                            mem_data_o  <= data_wr_q ? '0 : resp_data;
                            data_busy_q <= 1'b0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Capture comes last so a new request wins over the completion clear.
            if (inst_take) begin
                inst_busy_q <= 1'b1;
                inst_addr_q <= inst_addr_i[ADDR_WIDTH-1:1];
            end
            if (data_take) begin
                data_busy_q  <= 1'b1;
                data_addr_q  <= mem_addr_i[ADDR_WIDTH-1:2];
                data_wdata_q <= mem_data_i;
                data_wr_q    <= mem_write_i;
            end
        end
    end

endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// tb/tb_w0rm_mem_arbiter.sv - self-checking bench for w0rm_mem_arbiter
module tb_w0rm_mem_arbiter;

    logic        core_clk = 1'b0;
    logic        reset_n;
    logic [31:0] inst_addr_i;
    logic        inst_req_i;
    logic [15:0] inst_data_o;
    logic        inst_valid_o;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        mem_req_i;
    logic [31:0] mem_data_o;
    logic        mem_valid_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic        bus_read_o;
    logic        bus_write_o;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic [31:0] bus_data_i;
    logic        bus_valid_i;
    logic [1:0]  grant_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    w0rm_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .INST_WIDTH(16),
        .MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .core_clk(core_clk), .reset_n(reset_n),
        .inst_addr_i(inst_addr_i), .inst_req_i(inst_req_i),
        .inst_data_o(inst_data_o), .inst_valid_o(inst_valid_o),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_req_i(mem_req_i),
        .mem_data_o(mem_data_o), .mem_valid_o(mem_valid_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
        .bus_read_o(bus_read_o), .bus_write_o(bus_write_o), .bus_valid_o(bus_valid_o),
        .bus_ready_i(bus_ready_i), .bus_data_i(bus_data_i), .bus_valid_i(bus_valid_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        bit          is_data;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [127:0] all_outs();
        return {8'h0, inst_data_o, inst_valid_o, mem_data_o, mem_valid_o, bus_addr_o,
                bus_data_o, bus_read_o, bus_write_o, bus_valid_o, grant_o, err_o};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge core_clk);
        reset_n     = 1'b0;
        inst_req_i  = 1'b0;
        mem_req_i   = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        bus_ready_i = 1'b0;
        bus_valid_i = 1'b0;
        bus_data_i  = '0;
        #1;
        check("reset outputs", all_outs(), '0);
        @(negedge core_clk);
        reset_n = 1'b1;
        @(negedge core_clk);
    endtask

    task automatic issue(input bit i_req, input logic [31:0] iaddr, input bit d_req,
                         input bit rd, input bit wr, input logic [31:0] daddr,
                         input logic [31:0] wdata);
        inst_req_i  = i_req;
        inst_addr_i = iaddr;
        mem_req_i   = d_req;
        mem_read_i  = rd;
        mem_write_i = wr;
        mem_addr_i  = daddr;
        mem_data_i  = wdata;
        @(negedge core_clk);
        inst_req_i = 1'b0;
        mem_req_i  = 1'b0;
    endtask

    task automatic wait_bus(input string tag);
        int n = 0;
        while (!bus_valid_o && n < 20) begin
            @(negedge core_clk);
            n++;
        end
        check($sformatf("%s bus_valid", tag), bus_valid_o, 1'b1);
    endtask

    // Bus model: accepts at once, answers one cycle later; optionally pulses a data request alongside.
    task automatic serve(input string tag, input logic [1:0] exp_grant, input logic [31:0] exp_addr,
                         input bit exp_wr, input logic [31:0] exp_wdata,
                         input logic [31:0] rdata, input bit pulse_data);
        wait_bus(tag);
        check($sformatf("%s grant", tag), grant_o, exp_grant);
        check($sformatf("%s addr", tag), bus_addr_o, exp_addr);
        check($sformatf("%s rw", tag), {bus_read_o, bus_write_o}, {!exp_wr, exp_wr});
        if (exp_wr) check($sformatf("%s wdata", tag), bus_data_o, exp_wdata);
        bus_ready_i = 1'b1;
        @(negedge core_clk);
        bus_ready_i = 1'b0;
        check($sformatf("%s valid drop", tag), bus_valid_o, 1'b0);
        @(negedge core_clk);
        bus_valid_i = 1'b1;
        bus_data_i  = rdata;
        mem_req_i   = pulse_data;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b1;
        @(negedge core_clk);
        bus_valid_i = 1'b0;
        mem_req_i   = 1'b0;
    endtask

    task automatic check_resp(input string tag, input bit iv, input bit mv,
                              input logic [15:0] idata, input logic [31:0] mdata);
        check($sformatf("%s inst_valid", tag), inst_valid_o, iv);
        check($sformatf("%s mem_valid", tag), mem_valid_o, mv);
        if (iv) check($sformatf("%s inst_data", tag), inst_data_o, idata);
        if (mv) check($sformatf("%s mem_data", tag), mem_data_o, mdata);
        @(negedge core_clk);
        check($sformatf("%s strobe len", tag), {inst_valid_o, mem_valid_o}, 2'b00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 0, 32'h0000_0102, 32'h0, 32'hBEEF_CAFE, 32'h0000_BEEF};
        vecs[1] = '{0, 0, 32'h0000_0100, 32'h0, 32'hBEEF_CAFE, 32'h0000_CAFE};
        vecs[2] = '{0, 0, 32'h0000_03FE, 32'h0, 32'h1234_5678, 32'h0000_1234};
        vecs[3] = '{1, 0, 32'h0000_2003, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{1, 1, 32'h0000_0044, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'h0};
        vecs[5] = '{1, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0};

        inst_addr_i = '0;
        mem_addr_i  = '0;
        mem_data_i  = '0;
        reset_n     = 1'b1;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_data)
                issue(0, 0, 1, !vecs[i].wr, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            else
                issue(1, vecs[i].addr, 0, 0, 0, 0, 0);
            check($sformatf("vec%0d lat1", i), bus_valid_o, 1'b0);
            @(negedge core_clk);
            check($sformatf("vec%0d lat2", i), bus_valid_o, 1'b1);
            serve($sformatf("vec%0d", i), vecs[i].is_data ? 2'b10 : 2'b01,
                  {vecs[i].addr[31:2], 2'b00}, vecs[i].wr, vecs[i].wdata, vecs[i].rdata, 0);
            check_resp($sformatf("vec%0d", i), !vecs[i].is_data, vecs[i].is_data,
                       vecs[i].exp[15:0], vecs[i].exp);
        end
        check("vectors err", err_o, 1'b0);

        // Same-cycle fetch and data read: data first, each port gets its own data.
        issue(1, 32'h0000_0102, 1, 1, 0, 32'h0000_0300, 0);
        serve("both data", 2'b10, 32'h0000_0300, 0, 0, 32'h1111_2222, 0);
        check_resp("both data", 0, 1, 16'h0, 32'h1111_2222);
        serve("both inst", 2'b01, 32'h0000_0100, 0, 0, 32'h3333_4444, 0);
        check_resp("both inst", 1, 0, 16'h3333, 32'h0);

        // Fetch pending with five back-to-back writes: fetch slots in after the fourth.
        issue(1, 32'h0000_0200, 1, 0, 1, 32'h0000_1000, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            mem_addr_i = 32'h0000_1000 + 32'(4 * k);
            mem_data_i = 32'(k + 1);
            serve($sformatf("streak w%0d", k), 2'b10, 32'h0000_1000 + 32'(4 * (k - 1)),
                  1, 32'(k), 32'h0, 1);
            check_resp($sformatf("streak w%0d", k), 0, 1, 16'h0, 32'h0);
        end
        serve("streak inst", 2'b01, 32'h0000_0200, 0, 0, 32'h5555_AAAA, 0);
        check_resp("streak inst", 1, 0, 16'hAAAA, 32'h0);
        serve("streak w5", 2'b10, 32'h0000_1010, 1, 32'd5, 32'h0, 0);
        check_resp("streak w5", 0, 1, 16'h0, 32'h0);
        check("streak err", err_o, 1'b0);

        // Data read that never gets a bus response.
        issue(0, 0, 1, 1, 0, 32'h0000_0500, 0);
        wait_bus("tmo");
        bus_ready_i = 1'b1;
        @(negedge core_clk);
        bus_ready_i = 1'b0;
        repeat (7) @(negedge core_clk);
        check("tmo early", {mem_valid_o, err_o}, 2'b00);
        @(negedge core_clk);
        check("tmo valid", mem_valid_o, 1'b1);
        check("tmo data", mem_data_o, 32'h0);
        check("tmo err", err_o, 1'b1);

        // Second data request while the first is in flight is dropped.
        do_reset();
        issue(0, 0, 1, 1, 0, 32'h0000_0600, 0);
        wait_bus("drop");
        issue(0, 0, 1, 1, 0, 32'h0000_0700, 0);
        check("drop err", err_o, 1'b1);
        serve("drop first", 2'b10, 32'h0000_0600, 0, 0, 32'h6666_0000, 0);
        check_resp("drop first", 0, 1, 16'h0, 32'h6666_0000);
        repeat (4) @(negedge core_clk);
        check("drop no second", {bus_valid_o, grant_o}, 3'b000);

        // Reset while a fetch sits in REQ.
        issue(1, 32'h0000_0040, 0, 0, 0, 0, 0);
        wait_bus("rst mid");
        reset_n = 1'b0;
        #1;
        check("rst mid async", all_outs(), '0);
        @(negedge core_clk);
        reset_n = 1'b1;
        repeat (3) @(negedge core_clk);
        check("rst mid idle", {bus_valid_o, inst_valid_o, grant_o}, 4'b0);
        issue(1, 32'h0000_0000, 0, 0, 0, 0, 0);
        serve("rst after", 2'b01, 32'h0000_0000, 0, 0, 32'h1234_ABCD, 0);
        check_resp("rst after", 1, 0, 16'hABCD, 32'h0);
        check("rst after err", err_o, 1'b0);

        // Data request with both read and write set is rejected.
        issue(0, 0, 1, 1, 1, 32'h0000_0080, 0);
        check("badop err", err_o, 1'b1);
        repeat (4) @(negedge core_clk);
        check("badop no bus", {bus_valid_o, grant_o}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
